// File: rtl/fade_ola.sv
// -----------------------------------------------------------------------------
// fade_ola -- 50 % overlap-add stage of the fading-channel synthesis chain.
//
// Consumes windowed time-domain frames of N complex samples, each tagged with
// its in-frame index. The first half of every frame is summed with the stored
// second half of the previous frame and emitted as a saturated complex stream
// of N/2 samples per frame. The second half of each frame is stored in the
// tail buffer for the next frame.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   dv_in       in   input sample valid (no backpressure)
//   index       in   in-frame sample index, 0..N-1
//   din_imag    in   signed imaginary input sample
//   din_real    in   signed real input sample
//   dv_out      out  output sample valid (2 cycles after the head input)
//   dout_imag   out  signed saturated imaginary output
//   dout_real   out  signed saturated real output
//   dout_sof    out  first output sample of a hop (dout_index == 0)
//   dout_index  out  position within the hop, 0..N/2-1
//   frame_err   out  one-cycle pulse on an index sequence violation
//   sat_count   out  number of clamped output samples, sticks at 0xFFFF
// -----------------------------------------------------------------------------
module fade_ola #(
   parameter int N     = 32,
   parameter int W     = 16,
   parameter int IDX_W = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 dv_in,
   input  logic [IDX_W-1:0]     index,
   input  logic signed [W-1:0]  din_imag,
   input  logic signed [W-1:0]  din_real,
   output logic                 dv_out,
   output logic signed [W-1:0]  dout_imag,
   output logic signed [W-1:0]  dout_real,
   output logic                 dout_sof,
   output logic [IDX_W-2:0]     dout_index,
   output logic                 frame_err,
   output logic [15:0]          sat_count
);

   localparam int HALF = N / 2;

   localparam logic [IDX_W-1:0] IDX_ZERO      = '0;
   localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST_HEAD = IDX_W'(HALF - 1);
   localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(N - 1);

   localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      WAIT_SOF,
      HEAD,
      TAIL
   } state_t;

   state_t               state;
   state_t               next_state;
   logic [IDX_W-1:0]     expected;
   logic [IDX_W-1:0]     next_expected;

   // Decoded per-cycle actions.
   logic                 head_acc;   // sample accepted into the output path
   logic                 tail_wr;    // sample stored into the tail buffer
   logic                 seq_err;    // index sequence violation this cycle

   // Tail buffer: second half of the previous frame.
   logic signed [W-1:0]  tail_re [HALF];
   logic signed [W-1:0]  tail_im [HALF];

   // Low index bits address the tail in both halves because HALF is a power
   // of two: index-N/2 in the tail half equals these bits.
   logic [IDX_W-2:0]     tail_addr;
   logic signed [W-1:0]  rd_re;
   logic signed [W-1:0]  rd_im;
   logic signed [W:0]    sum_re;
   logic signed [W:0]    sum_im;

   // Pipeline stage 1: unsaturated sum.
   logic                 s1_valid;
   logic signed [W:0]    s1_re;
   logic signed [W:0]    s1_im;
   logic [IDX_W-2:0]     s1_idx;

   // Saturation of stage 1 result.
   logic signed [W-1:0]  sat_re;
   logic signed [W-1:0]  sat_im;
   logic                 clip_re;
   logic                 clip_im;

   assign tail_addr = index[IDX_W-2:0];

   // ---------------------------------------------------------------------------
   // Sequence decode
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case/if tree can leave a signal unassigned and infer a latch.
      head_acc      = 1'b0;
      tail_wr       = 1'b0;
      seq_err       = 1'b0;
      next_state    = state;
      next_expected = expected;

      if (dv_in) begin
         unique case (state)
            WAIT_SOF: begin
               // Anything but a frame start is dropped without complaint.
               if (index == IDX_ZERO) begin
                  head_acc      = 1'b1;
                  next_state    = HEAD;
                  next_expected = IDX_ONE;
               end
            end
            HEAD: begin
               if (index == expected) begin
                  head_acc      = 1'b1;
                  next_expected = index + IDX_ONE;
                  if (index == IDX_LAST_HEAD) next_state = TAIL;
               end else begin
                  seq_err = 1'b1;
               end
            end
            TAIL: begin
               if (index == expected) begin
                  tail_wr       = 1'b1;
                  // Wraps from N-1 to 0, the start of the next frame.
                  next_expected = index + IDX_ONE;
                  if (index == IDX_LAST) next_state = HEAD;
               end else begin
                  seq_err = 1'b1;
               end
            end
            default: begin
               next_state = WAIT_SOF;
            end
         endcase

         // A violating index 0 restarts a frame against the cleared tail.
         if (seq_err) begin
            if (index == IDX_ZERO) begin
               head_acc      = 1'b1;
               next_state    = HEAD;
               next_expected = IDX_ONE;
            end else begin
               next_state    = WAIT_SOF;
               next_expected = IDX_ZERO;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Overlap sum (W+1 bits, cannot overflow)
   // ---------------------------------------------------------------------------
   always_comb begin
      // The tail is being cleared this cycle on a violation, so a restarted
      // frame must already see zeros.
      rd_re = '0;
      rd_im = '0;
      if (!seq_err) begin
         rd_re = tail_re[tail_addr];
         rd_im = tail_im[tail_addr];
      end
      sum_re = {din_real[W-1], din_real} + {rd_re[W-1], rd_re};
      sum_im = {din_imag[W-1], din_imag} + {rd_im[W-1], rd_im};
   end

   // ---------------------------------------------------------------------------
   // Clamp to W bits: overflow iff the two top bits of the W+1 sum differ.
   // ---------------------------------------------------------------------------
   always_comb begin
      clip_re = (s1_re[W] != s1_re[W-1]);
      clip_im = (s1_im[W] != s1_im[W-1]);
      sat_re  = s1_re[W-1:0];
      sat_im  = s1_im[W-1:0];
      if (clip_re) sat_re = s1_re[W] ? SAT_MIN : SAT_MAX;
      if (clip_im) sat_im = s1_im[W] ? SAT_MIN : SAT_MAX;
   end

   // ---------------------------------------------------------------------------
   // Sequencing FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state     <= WAIT_SOF;
         expected  <= IDX_ZERO;
         frame_err <= 1'b0;
      end else begin
         state     <= next_state;
         expected  <= next_expected;
         frame_err <= seq_err;
      end
   end

   // ---------------------------------------------------------------------------
   // Tail buffer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: this storage is deliberately built from resettable flops, not a
      // RAM: both reset and a sequence violation must zero all entries at once.
      if (reset) begin
         for (int i = 0; i < HALF; i++) begin
            tail_re[i] <= '0;
            tail_im[i] <= '0;
         end
      end else if (seq_err) begin
         for (int i = 0; i < HALF; i++) begin
            tail_re[i] <= '0;
            tail_im[i] <= '0;
         end
      end else if (tail_wr) begin
         tail_re[tail_addr] <= din_real;
         tail_im[tail_addr] <= din_imag;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: registered sum
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_re    <= '0;
         s1_im    <= '0;
         s1_idx   <= '0;
      end else begin
         s1_valid <= head_acc;
         if (head_acc) begin
            s1_re  <= sum_re;
            s1_im  <= sum_im;
            s1_idx <= tail_addr;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: registered saturated output and clip statistics
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dv_out     <= 1'b0;
         dout_real  <= '0;
         dout_imag  <= '0;
         dout_sof   <= 1'b0;
         dout_index <= '0;
         sat_count  <= '0;
      end else begin
         dv_out   <= s1_valid;
         dout_sof <= s1_valid && (s1_idx == '0);
         if (s1_valid) begin
            dout_real  <= sat_re;
            dout_imag  <= sat_im;
            dout_index <= s1_idx;
            if ((clip_re || clip_im) && (sat_count != 16'hFFFF)) begin
               sat_count <= sat_count + 16'd1;
            end
         end
      end
   end

endmodule

// File: doc/fade_ola.md
# fade_ola

Overlap-add stage for the fading-channel synthesis chain. It sits directly downstream of the `win` windower, which in turn follows the `fade_ifft` IFFT. The block consumes windowed time-domain frames of N complex samples, tagged with their in-frame index. It sums the first half of each frame with the stored second half of the previous frame (50 % overlap, hop N/2) and emits a continuous, saturated complex sample stream of N/2 samples per frame.

## Interface
- `N`, 32, frame length; power of two, ≥ 4.
- `W`, 16, signed sample width, real and imag.
- `IDX_W`, 5, index width = log2(N).

- `clk`  in  1  — single clock; everything is synchronous to its rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `dv_in`  in  1  — input sample valid; no backpressure.
- `index`  in  IDX_W  — in-frame sample index, 0..N-1.
- `din_imag`  in  W  — signed imaginary input.
- `din_real`  in  W  — signed real input.
- `dv_out`  out  1  — output sample valid.
- `dout_imag`  out  W  — signed imaginary output.
- `dout_real`  out  W  — signed real output.
- `dout_sof`  out  1  — high with `dv_out` on the first output sample of each hop.
- `dout_index`  out  IDX_W-1  — position within hop, 0..N/2-1.
- `frame_err`  out  1  — one-cycle pulse on an index sequence violation.
- `sat_count`  out  16  — count of saturated output samples; sticks at 0xFFFF.

## Operation
- Tail buffer: N/2 complex entries, cleared to 0 by reset.
- FSM states:
  - WAIT_SOF: reset state. Samples with `index`≠0 are dropped silently and do not raise `frame_err`. `index`=0 → HEAD.
  - HEAD: accepts indices 0..N/2-1. Each accepted sample produces one output = din + tail[index].
  - TAIL: accepts indices N/2..N-1. Each accepted sample writes tail[index-N/2] ← din and produces no output.
- Sequencing: `expected` advances by 1 on each accepted sample.
  - HEAD→TAIL after index N/2-1.
  - TAIL→HEAD after index N-1, expecting index 0 of the next frame.
  - Cycles with `dv_in` low are ignored and do not change state.
- Sequence violation (`dv_in` with `index`≠`expected`, in HEAD or TAIL):
  - `frame_err` pulses; the whole tail buffer is cleared; the offending sample is not output.
  - If the offending index is 0, it is accepted as the start of a new frame against the cleared tail (tail read = 0) and the FSM enters HEAD.
  - Otherwise the FSM goes to WAIT_SOF.
- Arithmetic:
  - Real and imag are each summed at W+1 bits, then clamped to [-2^(W-1), 2^(W-1)-1].
  - `sat_count` increments by 1 per output sample in which either component clamped; it saturates at 0xFFFF.
- Tail read/write hazard: none. A tail entry is always written at least N/2 accepted samples before it is read.

## Timing
- Latency: a HEAD sample accepted at cycle t appears on `dv_out` at t+2.
  - Stage 1 registers the sum; stage 2 registers the saturated result.
- Output rate equals the HEAD input rate; gaps on `dv_in` propagate unchanged.
- `dout_sof` = `dv_out` && (`dout_index`==0).
- `frame_err` is asserted at t+1 for a violating sample at t, for exactly one cycle.
- Reset values: `dv_out`=0, `dout_imag`=0, `dout_real`=0, `dout_sof`=0, `dout_index`=0, `frame_err`=0, `sat_count`=0.
- Reset mid-frame:
  - Pipeline valids are cleared immediately, so in-flight samples never emerge.
  - The tail is zeroed and the FSM returns to WAIT_SOF.
- Tail updates at end of cycle t become visible to reads from cycle t+1.

## Test plan
- Reset, then one contiguous frame with real=1000, imag=−500, index 0..31 → 16 outputs of (1000, −500); `dout_sof` on the first; each output 2 cycles after its input; `frame_err`=0.
- Two back-to-back frames of the same data → second hop outputs (2000, −1000); first-hop outputs unchanged.
- Frame of 30000 followed by a frame of 30000 → 32767 on all 16 second-hop outputs and `sat_count`=16. Repeat with −30000 → −32768 and `sat_count`=32.
- Indices 0..9, then 11 → `frame_err` pulse one cycle after index 11; only 10 outputs; FSM in WAIT_SOF. Next frame of 700 → outputs 700 (tail was cleared).
- Random 0–3 idle cycles between valid samples over 4 frames → output values and order identical to the gap-free run, and each `dv_out` 2 cycles after its HEAD input.
- Assert `reset` for 1 cycle at index 20 of frame 2 → outputs 0 and `dv_out` 0 from the reset edge. The following frame of 1000 yields 1000 on its outputs, not 2000.
